// File: rtl/decode_regread_pkg.sv
// Shared constants, field positions, decoded-bundle type and immediate helpers
// for the decode/register-read stage.
package decode_regread_pkg;

   localparam int DATA_W    = 16;
   localparam int REG_COUNT = 8;
   localparam int PC_W      = 16;
   localparam int INSTR_W   = 16;
   localparam int REG_AW    = $clog2(REG_COUNT);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_SW   = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_JALR = 3'b111;

   // LSB positions of the instruction fields
   localparam int F_OP_LO   = 13;
   localparam int F_RA_LO   = 10;
   localparam int F_RB_LO   = 7;
   localparam int F_RC_LO   = 0;
   localparam int F_IMM7_W  = 7;
   localparam int F_IMM10_W = 10;

   typedef struct packed {
      logic [2:0]        opcode;
      logic [REG_AW-1:0] tgt;
      logic [DATA_W-1:0] op_a;
      logic [DATA_W-1:0] op_b;
      logic [DATA_W-1:0] imm;
      logic [PC_W-1:0]   pc;
      logic              bubble;
   } bundle_t;

   // Invalid bundle: tgt=0 guarantees writeback never commits it
   localparam bundle_t BUBBLE_BUNDLE = '{opcode: '0, tgt: '0, op_a: '0, op_b: '0,
                                         imm: '0, pc: '0, bubble: 1'b1};

   function automatic logic [DATA_W-1:0] sext7(input logic [F_IMM7_W-1:0] v);
      return {{(DATA_W-F_IMM7_W){v[F_IMM7_W-1]}}, v};
   endfunction

   function automatic logic [DATA_W-1:0] lui_imm(input logic [F_IMM10_W-1:0] v);
      return {v, {(DATA_W-F_IMM10_W){1'b0}}};
   endfunction

endpackage

// File: rtl/decode_regread_if.sv
// Decode-stage bus: fetch side, writeback write port, and registered bundle
// to execute. master = surrounding pipeline, slave = decode stage.
interface decode_regread_if;
   import decode_regread_pkg::*;

   logic [INSTR_W-1:0] instr_in;
   logic [PC_W-1:0]    pc_in;
   logic               bubble_in;
   logic               stall_in;
   logic               flush_in;
   logic               wb_we;
   logic [REG_AW-1:0]  wb_tgt;
   logic [DATA_W-1:0]  wb_data;
   logic               stall_out;
   logic [2:0]         opcode_out;
   logic [REG_AW-1:0]  tgt_out;
   logic [DATA_W-1:0]  op_a_out;
   logic [DATA_W-1:0]  op_b_out;
   logic [DATA_W-1:0]  imm_out;
   logic [PC_W-1:0]    pc_out;
   logic               bubble_out;

   modport master (
      output instr_in, pc_in, bubble_in, stall_in, flush_in, wb_we, wb_tgt, wb_data,
      input  stall_out, opcode_out, tgt_out, op_a_out, op_b_out, imm_out, pc_out, bubble_out
   );

   modport slave (
      input  instr_in, pc_in, bubble_in, stall_in, flush_in, wb_we, wb_tgt, wb_data,
      output stall_out, opcode_out, tgt_out, op_a_out, op_b_out, imm_out, pc_out, bubble_out
   );

endinterface

// File: rtl/decode_regread_regfile_2r1w.sv
// REG_COUNT x DATA_W register file: two async reads, one sync write,
// r0 hardwired to zero, async active-low reset clears every register.
module regfile_2r1w #(
   parameter  int DATA_W    = 16,
   parameter  int REG_COUNT = 8,
   localparam int AW        = $clog2(REG_COUNT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr_a,
   input  logic [AW-1:0]     raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   logic [REG_COUNT-1:0][DATA_W-1:0] regs_d, regs_q;

   // Next-state: single write port, writes to r0 dropped
   always_comb begin
      regs_d = regs_q;
      if (we && waddr != '0) regs_d[waddr] = wdata;
      regs_d[0] = '0;
   end

   // Storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) regs_q <= '0;
      else        regs_q <= regs_d;
   end

   assign rdata_a = regs_q[raddr_a];
   assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/decode_regread.sv
// Decode + register-read stage. Decodes the RiSC-style instruction, reads up to
// two operands and registers the bundle for execute (1-cycle latency).
// Build option WB_BYPASS_EN: forward same-cycle writeback data to the reads
// (stall_out tied 0). Default: no forwarding; a read of a register being
// written this cycle raises stall_out and the retry sees the committed value.
module decode_regread
   import decode_regread_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   decode_regread_if.slave io
);

   logic [2:0]        op;
   logic [REG_AW-1:0] ra, rb, rc;
   logic [REG_AW-1:0] src_a, src_b, dec_tgt;
   logic              use_a, use_b;
   logic [DATA_W-1:0] dec_imm;
   logic [DATA_W-1:0] rf_a, rf_b, rd_a, rd_b, opnd_a, opnd_b;
   logic              wb_hit, dec_stall;
   bundle_t           bundle_d, bundle_q;

   assign op     = io.instr_in[F_OP_LO +: 3];
   assign ra     = io.instr_in[F_RA_LO +: REG_AW];
   assign rb     = io.instr_in[F_RB_LO +: REG_AW];
   assign rc     = io.instr_in[F_RC_LO +: REG_AW];
   assign wb_hit = io.wb_we && (io.wb_tgt != '0);

   // Per-opcode source selection, destination and immediate
   always_comb begin
      src_a   = '0;
      src_b   = '0;
      use_a   = 1'b0;
      use_b   = 1'b0;
      dec_tgt = '0;
      dec_imm = '0;
      case (op)
         OP_ADD, OP_NAND: begin
            src_a = rb; use_a = 1'b1; src_b = rc; use_b = 1'b1; dec_tgt = ra;
         end
         OP_ADDI, OP_LW: begin
            src_a = rb; use_a = 1'b1; dec_tgt = ra;
            dec_imm = sext7(io.instr_in[F_IMM7_W-1:0]);
         end
         OP_LUI: begin
            dec_tgt = ra;
            dec_imm = lui_imm(io.instr_in[F_IMM10_W-1:0]);
         end
         OP_SW: begin
            src_a = rb; use_a = 1'b1; src_b = ra; use_b = 1'b1;
            dec_imm = sext7(io.instr_in[F_IMM7_W-1:0]);
         end
         OP_BEQ: begin
            src_a = ra; use_a = 1'b1; src_b = rb; use_b = 1'b1;
            dec_imm = sext7(io.instr_in[F_IMM7_W-1:0]);
         end
         OP_JALR: begin
            src_a = rb; use_a = 1'b1; dec_tgt = ra;
         end
         default: ;
      endcase
   end

   regfile_2r1w #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT)) u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (io.wb_we),
      .waddr   (io.wb_tgt),
      .wdata   (io.wb_data),
      .raddr_a (src_a),
      .raddr_b (src_b),
      .rdata_a (rf_a),
      .rdata_b (rf_b)
   );

   // Operand read: optional forwarding of the in-flight write (never for r0)
   always_comb begin
      rd_a = rf_a;
      rd_b = rf_b;
`ifdef WB_BYPASS_EN
      if (wb_hit && io.wb_tgt == src_a) rd_a = io.wb_data;
      if (wb_hit && io.wb_tgt == src_b) rd_b = io.wb_data;
`endif
      opnd_a = use_a ? rd_a : '0;
      opnd_b = use_b ? rd_b : '0;
   end

`ifdef WB_BYPASS_EN
   assign dec_stall = 1'b0;
`else
   // Without forwarding, a used source being written this cycle must retry;
   // held low during reset so fetch is not blocked by stale inputs
   assign dec_stall = rst_n && !io.bubble_in && wb_hit &&
                      ((use_a && src_a == io.wb_tgt) || (use_b && src_b == io.wb_tgt));
`endif

   assign io.stall_out = dec_stall;

   // Output bundle next-state: flush > stall_in hold > bubble/stall > load
   always_comb begin
      bundle_d = bundle_q;
      if (io.flush_in) begin
         bundle_d = BUBBLE_BUNDLE;
      end else if (io.stall_in) begin
         bundle_d = bundle_q;
      end else if (io.bubble_in || dec_stall) begin
         bundle_d = BUBBLE_BUNDLE;
      end else begin
         bundle_d = '{opcode: op, tgt: dec_tgt, op_a: opnd_a, op_b: opnd_b,
                      imm: dec_imm, pc: io.pc_in, bubble: 1'b0};
      end
   end

   // Output register; reset discards any in-flight bundle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bundle_q <= BUBBLE_BUNDLE;
      else        bundle_q <= bundle_d;
   end

   assign io.opcode_out = bundle_q.opcode;
   assign io.tgt_out    = bundle_q.tgt;
   assign io.op_a_out   = bundle_q.op_a;
   assign io.op_b_out   = bundle_q.op_b;
   assign io.imm_out    = bundle_q.imm;
   assign io.pc_out     = bundle_q.pc;
   assign io.bubble_out = bundle_q.bubble;

endmodule

// File: tb/tb_decode_regread.sv
// Bench for decode_regread: directed scenarios plus randomized traffic
// checked against an instruction-level model of the register file and decode.
module tb_decode_regread;
   import decode_regread_pkg::*;

`ifdef WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   decode_regread_if dif();

   decode_regread dut (.clk(clk), .rst_n(rst_n), .io(dif));

   int checks = 0;
   int failures = 0;

   logic [15:0] m_regs [8];
   // expected registered outputs now, and predicted after the next edge
   logic [2:0]  e_op, e_tgt, n_op, n_tgt;
   logic [15:0] e_a, e_b, e_imm, e_pc, n_a, n_b, n_imm, n_pc;
   logic        e_bub, n_bub;
   logic        e_stall;

   function automatic logic [15:0] rd(input logic [2:0] r);
      if (r == 3'd0) return 16'h0;
      if (BYPASS && dif.wb_we && dif.wb_tgt == r) return dif.wb_data;
      return m_regs[r];
   endfunction

   task automatic reset_model();
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
      e_op = 0; e_tgt = 0; e_a = 0; e_b = 0; e_imm = 0; e_pc = 0; e_bub = 1'b1;
      n_op = 0; n_tgt = 0; n_a = 0; n_b = 0; n_imm = 0; n_pc = 0; n_bub = 1'b1;
   endtask

   // Drive one cycle of inputs and predict stall_out and the next bundle
   task automatic set_in(input logic [15:0] instr, input logic [15:0] pc,
                         input logic bub, input logic stl, input logic fl,
                         input logic we, input logic [2:0] tgt, input logic [15:0] data);
      logic [2:0] op, ra, rb, rc, sa, sb, t;
      logic       ua, ub;
      logic [15:0] imm, s7, a, b;
      dif.instr_in = instr; dif.pc_in = pc; dif.bubble_in = bub; dif.stall_in = stl;
      dif.flush_in = fl; dif.wb_we = we; dif.wb_tgt = tgt; dif.wb_data = data;
      op = instr[15:13]; ra = instr[12:10]; rb = instr[9:7]; rc = instr[2:0];
      s7 = (instr[6:0] >= 7'd64) ? 16'(instr[6:0]) - 16'd128 : 16'(instr[6:0]);
      ua = 0; ub = 0; sa = 0; sb = 0; imm = 0; t = 0;
      case (op)
         3'd0, 3'd2: begin sa = rb; sb = rc; ua = 1; ub = 1; t = ra; end
         3'd1, 3'd5: begin sa = rb; ua = 1; imm = s7; t = ra; end
         3'd3:       begin imm = 16'(instr[9:0]) * 16'd64; t = ra; end
         3'd4:       begin sa = rb; sb = ra; ua = 1; ub = 1; imm = s7; end
         3'd6:       begin sa = ra; sb = rb; ua = 1; ub = 1; imm = s7; end
         default:    begin sa = rb; ua = 1; t = ra; end
      endcase
      a = ua ? rd(sa) : 16'h0;
      b = ub ? rd(sb) : 16'h0;
      e_stall = !BYPASS && !bub && we && tgt != 0 && ((ua && sa == tgt) || (ub && sb == tgt));
      if (fl) begin
         n_bub = 1; n_tgt = 0;
      end else if (stl) begin
         n_op = e_op; n_tgt = e_tgt; n_a = e_a; n_b = e_b; n_imm = e_imm; n_pc = e_pc; n_bub = e_bub;
      end else if (bub || e_stall) begin
         n_bub = 1; n_tgt = 0;
      end else begin
         n_op = op; n_tgt = t; n_a = a; n_b = b; n_imm = imm; n_pc = pc; n_bub = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
      e_op = n_op; e_tgt = n_tgt; e_a = n_a; e_b = n_b; e_imm = n_imm; e_pc = n_pc; e_bub = n_bub;
      if (dif.wb_we && dif.wb_tgt != 0) m_regs[dif.wb_tgt] = dif.wb_data;
   endtask

   task automatic test_reset();
      reset_model();
      set_in(16'h0, 16'h0, 1, 0, 0, 0, 3'd0, 16'h0);
      #12;
      checks++;
      if (dif.bubble_out !== 1'b1 || {dif.opcode_out, dif.tgt_out, dif.op_a_out, dif.op_b_out, dif.imm_out, dif.pc_out} !== 70'h0) begin
         failures++; $display("FAIL reset_init bub=%b tgt=%0d a=%h b=%h imm=%h pc=%h", dif.bubble_out, dif.tgt_out, dif.op_a_out, dif.op_b_out, dif.imm_out, dif.pc_out);
      end
      @(negedge clk) rst_n = 1'b1;
      // fill registers with non-zero data, then reset mid-stream
      for (int r = 1; r < 8; r++) begin
         set_in({3'b000, 3'(r), 3'(r), 4'd0, 3'(r)}, 16'(r), 0, 0, 0, 1, 3'(r), 16'hA000 + 16'(r));
         tick();
      end
      set_in({3'b000, 3'd1, 3'd3, 4'd0, 3'd3}, 16'h55, 0, 0, 0, 1, 3'd3, 16'h1111);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (dif.bubble_out !== 1'b1 || dif.stall_out !== 1'b0 || {dif.opcode_out, dif.tgt_out, dif.op_a_out, dif.op_b_out, dif.imm_out, dif.pc_out} !== 70'h0) begin
         failures++; $display("FAIL reset_mid bub=%b stall=%b tgt=%0d a=%h b=%h imm=%h pc=%h", dif.bubble_out, dif.stall_out, dif.tgt_out, dif.op_a_out, dif.op_b_out, dif.imm_out, dif.pc_out);
      end
      reset_model();
      set_in(16'h0, 16'h0, 1, 0, 0, 0, 3'd0, 16'h0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      for (int r = 1; r < 8; r++) begin
         set_in({3'b000, 3'd0, 3'(r), 4'd0, 3'(r)}, 16'h100, 0, 0, 0, 0, 3'd0, 16'h0);
         tick();
         checks++;
         if (dif.op_a_out !== 16'h0 || dif.op_b_out !== 16'h0 || dif.bubble_out !== 1'b0) begin
            failures++; $display("FAIL reset_read r%0d a=%h b=%h bub=%b want 0 0 0", r, dif.op_a_out, dif.op_b_out, dif.bubble_out);
         end
      end
   endtask

   task automatic test_write_add();
      set_in(16'h0, 16'h10, 1, 0, 0, 1, 3'd3, 16'h1234);
      tick();
      set_in({3'b000, 3'd1, 3'd3, 4'd0, 3'd3}, 16'h12, 0, 0, 0, 0, 3'd0, 16'h0);
      tick();
      checks++;
      if ({dif.op_a_out, dif.op_b_out, dif.tgt_out, dif.bubble_out, dif.pc_out} !== {16'h1234, 16'h1234, 3'd1, 1'b0, 16'h12}) begin
         failures++; $display("FAIL write_add a=%h b=%h tgt=%0d bub=%b pc=%h want 1234 1234 1 0 0012", dif.op_a_out, dif.op_b_out, dif.tgt_out, dif.bubble_out, dif.pc_out);
      end
   endtask

   task automatic test_hazard();
      logic [15:0] beq;
      beq = {3'b110, 3'd5, 3'd0, 7'h7F};
      set_in(beq, 16'h20, 0, 0, 0, 1, 3'd5, 16'hBEEF);
      #1;
      checks++;
      if (dif.stall_out !== !BYPASS) begin
         failures++; $display("FAIL hazard_stall got=%b want=%b", dif.stall_out, !BYPASS);
      end
      tick();
      checks++;
      if (BYPASS) begin
         if ({dif.op_a_out, dif.op_b_out, dif.imm_out, dif.tgt_out, dif.bubble_out} !== {16'hBEEF, 16'h0, 16'hFFFF, 3'd0, 1'b0}) begin
            failures++; $display("FAIL hazard_bypass a=%h b=%h imm=%h tgt=%0d bub=%b want beef 0000 ffff 0 0", dif.op_a_out, dif.op_b_out, dif.imm_out, dif.tgt_out, dif.bubble_out);
         end
      end else if (dif.bubble_out !== 1'b1 || dif.tgt_out !== 3'd0) begin
         failures++; $display("FAIL hazard_bubble bub=%b tgt=%0d want 1 0", dif.bubble_out, dif.tgt_out);
      end
      set_in(beq, 16'h20, 0, 0, 0, 0, 3'd0, 16'h0);
      tick();
      checks++;
      if ({dif.op_a_out, dif.imm_out, dif.bubble_out, dif.opcode_out} !== {16'hBEEF, 16'hFFFF, 1'b0, 3'd6}) begin
         failures++; $display("FAIL hazard_retry a=%h imm=%h bub=%b op=%0d want beef ffff 0 6", dif.op_a_out, dif.imm_out, dif.bubble_out, dif.opcode_out);
      end
   endtask

   task automatic test_r0();
      set_in({3'b000, 3'd2, 3'd0, 4'd0, 3'd0}, 16'h30, 0, 0, 0, 1, 3'd0, 16'hFFFF);
      #1;
      checks++;
      if (dif.stall_out !== 1'b0) begin
         failures++; $display("FAIL r0_stall got=%b want=0", dif.stall_out);
      end
      tick();
      set_in({3'b000, 3'd2, 3'd0, 4'd0, 3'd0}, 16'h31, 0, 0, 0, 0, 3'd0, 16'h0);
      checks++;
      if ({dif.op_a_out, dif.op_b_out, dif.tgt_out} !== {16'h0, 16'h0, 3'd2}) begin
         failures++; $display("FAIL r0_same a=%h b=%h tgt=%0d want 0 0 2", dif.op_a_out, dif.op_b_out, dif.tgt_out);
      end
      tick();
      checks++;
      if ({dif.op_a_out, dif.op_b_out} !== 32'h0) begin
         failures++; $display("FAIL r0_after a=%h b=%h want 0 0", dif.op_a_out, dif.op_b_out);
      end
      set_in({3'b011, 3'd4, 10'h3FF}, 16'h32, 0, 0, 0, 0, 3'd0, 16'h0);
      tick();
      checks++;
      if ({dif.imm_out, dif.tgt_out, dif.opcode_out, dif.op_a_out, dif.op_b_out} !== {16'hFFC0, 3'd4, 3'd3, 16'h0, 16'h0}) begin
         failures++; $display("FAIL lui imm=%h tgt=%0d op=%0d a=%h b=%h want ffc0 4 3 0 0", dif.imm_out, dif.tgt_out, dif.opcode_out, dif.op_a_out, dif.op_b_out);
      end
   endtask

   task automatic test_stall();
      set_in({3'b000, 3'd1, 3'd3, 4'd0, 3'd3}, 16'h40, 0, 0, 0, 0, 3'd0, 16'h0);
      tick();
      for (int c = 0; c < 3; c++) begin
         set_in(16'($urandom), 16'($urandom), 0, 1, 0, (c == 0), 3'd7, 16'h7777);
         tick();
         checks++;
         if ({dif.op_a_out, dif.op_b_out, dif.tgt_out, dif.pc_out, dif.bubble_out, dif.opcode_out} !== {16'h1234, 16'h1234, 3'd1, 16'h40, 1'b0, 3'd0}) begin
            failures++; $display("FAIL stall_hold c%0d a=%h b=%h tgt=%0d pc=%h bub=%b want 1234 1234 1 0040 0", c, dif.op_a_out, dif.op_b_out, dif.tgt_out, dif.pc_out, dif.bubble_out);
         end
      end
      set_in({3'b000, 3'd1, 3'd3, 4'd0, 3'd3}, 16'h44, 0, 1, 1, 0, 3'd0, 16'h0);
      tick();
      checks++;
      if (dif.bubble_out !== 1'b1 || dif.tgt_out !== 3'd0) begin
         failures++; $display("FAIL flush_stall bub=%b tgt=%0d want 1 0", dif.bubble_out, dif.tgt_out);
      end
      set_in({3'b000, 3'd0, 3'd7, 4'd0, 3'd7}, 16'h48, 0, 0, 0, 0, 3'd0, 16'h0);
      tick();
      checks++;
      if (dif.op_a_out !== 16'h7777) begin
         failures++; $display("FAIL stall_write a=%h want 7777", dif.op_a_out);
      end
   endtask

   task automatic test_sw_bubble();
      set_in(16'h0, 16'h0, 1, 0, 0, 1, 3'd2, 16'h2222);
      tick();
      set_in(16'h0, 16'h0, 1, 0, 0, 1, 3'd6, 16'h6666);
      tick();
      set_in({3'b100, 3'd6, 3'd2, 7'h7F}, 16'h50, 0, 0, 0, 0, 3'd0, 16'h0);
      tick();
      checks++;
      if ({dif.tgt_out, dif.op_a_out, dif.op_b_out, dif.imm_out, dif.opcode_out, dif.bubble_out} !== {3'd0, 16'h2222, 16'h6666, 16'hFFFF, 3'd4, 1'b0}) begin
         failures++; $display("FAIL sw tgt=%0d a=%h b=%h imm=%h op=%0d bub=%b want 0 2222 6666 ffff 4 0", dif.tgt_out, dif.op_a_out, dif.op_b_out, dif.imm_out, dif.opcode_out, dif.bubble_out);
      end
      set_in({3'b000, 3'd1, 3'd3, 4'd0, 3'd3}, 16'h52, 1, 0, 0, 0, 3'd0, 16'h0);
      tick();
      checks++;
      if (dif.bubble_out !== 1'b1 || dif.tgt_out !== 3'd0) begin
         failures++; $display("FAIL bubble_in bub=%b tgt=%0d want 1 0", dif.bubble_out, dif.tgt_out);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         set_in(16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
         #1;
         checks++;
         if (dif.stall_out !== e_stall) begin
            failures++; $display("FAIL rand_stall i=%0d got=%b want=%b", i, dif.stall_out, e_stall);
         end
         tick();
         checks++;
         if (dif.bubble_out !== e_bub || dif.tgt_out !== e_tgt ||
             (!e_bub && {dif.opcode_out, dif.op_a_out, dif.op_b_out, dif.imm_out, dif.pc_out} !== {e_op, e_a, e_b, e_imm, e_pc})) begin
            failures++;
            $display("FAIL rand_out i=%0d got bub=%b tgt=%0d op=%0d a=%h b=%h imm=%h pc=%h want bub=%b tgt=%0d op=%0d a=%h b=%h imm=%h pc=%h",
                     i, dif.bubble_out, dif.tgt_out, dif.opcode_out, dif.op_a_out, dif.op_b_out, dif.imm_out, dif.pc_out,
                     e_bub, e_tgt, e_op, e_a, e_b, e_imm, e_pc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_add();
      test_hazard();
      test_r0();
      test_stall();
      test_sw_bubble();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
